// File: rtl/bayer_mosaic.sv
// -----------------------------------------------------------------------------
// bayer_mosaic
//
// Turns a stream of RGB pixels into a Bayer (RGGB) sample stream. Each pixel
// accepted inside a frame produces one 8-bit sample at its (x,y) position:
// red on even/even sites, blue on odd/odd sites, green elsewhere. The output
// stage is a single registered slot with one cycle of latency. It runs at
// full throughput, and a stalled sample holds steady until downstream takes it.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready        RGB input handshake
//   in_sof                     first pixel of a frame
//   in_red/in_green/in_blue    RGB channels
//   out_valid / out_ready      Bayer sample handshake
//   out_data                   selected channel
//   out_x / out_y              sample position
//   out_sof/out_eol/out_eof    first pixel / last of row / last of frame
//   sof_err                    pulse: in_sof arrived mid-frame (frame restarted)
//   frame_done                 pulse: the eof sample was taken downstream
// -----------------------------------------------------------------------------
module bayer_mosaic #(
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_red,
    input  logic [7:0] in_green,
    input  logic [7:0] in_blue,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [5:0] out_x,
    output logic [4:0] out_y,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof,
    output logic       sof_err,
    output logic       frame_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [5:0] x_q, x_d;
    logic [4:0] y_q, y_d;

    logic       outValid_q;
    logic [7:0] outData_q;
    logic [5:0] outX_q;
    logic [4:0] outY_q;
    logic       outSof_q;
    logic       outEol_q;
    logic       outEof_q;
    logic       sofErr_q;
    logic       frameDone_q;

    logic       accept;
    logic       outFire;
    logic       emit;
    logic [5:0] posX;
    logic [4:0] posY;
    logic       lastCol;
    logic       lastRow;
    logic [7:0] sample;

    // The slot can take a new pixel when it is empty or being drained now.
    assign in_ready = !outValid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign outFire  = outValid_q && out_ready;

    // An in_sof pixel always lands at (0,0), whether it opens a frame from
    // IDLE or restarts one mid-frame. Pixels seen in IDLE without in_sof are
    // dropped silently.
    assign emit    = accept && (in_sof || state_q == RUN);
    assign posX    = in_sof ? 6'd0 : x_q;
    assign posY    = in_sof ? 5'd0 : y_q;
    assign lastCol = (posX == 6'(WIDTH - 1));
    assign lastRow = (posY == 5'(HEIGHT - 1));

    // RGGB site selection from the column and row parity.
    always_comb begin
        sample = in_green;
        case ({posX[0], posY[0]})
            2'b00:   sample = in_red;
            2'b11:   sample = in_blue;
            default: sample = in_green;
        endcase
    end

    // Raster position and frame state advance once per emitted sample.
    // The last pixel of the frame sends the FSM back to IDLE, so the next
    // frame must be opened with in_sof.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (emit) begin
            if (lastCol && lastRow) begin
                state_d = IDLE;
                x_d     = 6'd0;
                y_d     = 5'd0;
            end else begin
                state_d = RUN;
                if (lastCol) begin
                    x_d = 6'd0;
                    y_d = posY + 5'd1;
                end else begin
                    x_d = posX + 6'd1;
                    y_d = posY;
                end
            end
        end
    end

    // State, counters and the output slot. The sample fields change only
    // when a new sample is loaded, so they hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= 6'd0;
            y_q         <= 5'd0;
            outValid_q  <= 1'b0;
            outData_q   <= 8'd0;
            outX_q      <= 6'd0;
            outY_q      <= 5'd0;
            outSof_q    <= 1'b0;
            outEol_q    <= 1'b0;
            outEof_q    <= 1'b0;
            sofErr_q    <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sofErr_q    <= accept && in_sof && (state_q == RUN) &&
                           ((x_q != 6'd0) || (y_q != 5'd0));
            frameDone_q <= outFire && outEof_q;
            if (emit) begin
                outValid_q <= 1'b1;
                outData_q  <= sample;
                outX_q     <= posX;
                outY_q     <= posY;
                outSof_q   <= (posX == 6'd0) && (posY == 5'd0);
                outEol_q   <= lastCol;
                outEof_q   <= lastCol && lastRow;
            end else if (outFire) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_data   = outData_q;
    assign out_x      = outX_q;
    assign out_y      = outY_q;
    assign out_sof    = outSof_q;
    assign out_eol    = outEol_q;
    assign out_eof    = outEof_q;
    assign sof_err    = sofErr_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_bayer_mosaic.sv
// -----------------------------------------------------------------------------
// tb_bayer_mosaic
//
// Scoreboard bench for bayer_mosaic. The driver applies pixels. A frame model
// based on the linear pixel index pushes the expected sample when a pixel is
// accepted. A separate monitor pops and compares each sample that leaves the
// block. It also checks stall stability, the in_ready rule and frame_done
// timing.
// -----------------------------------------------------------------------------
module tb_bayer_mosaic;

    localparam int W = 40;
    localparam int H = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sof = 1'b0;
    logic [7:0] in_red = 8'd0;
    logic [7:0] in_green = 8'd0;
    logic [7:0] in_blue = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [5:0] out_x;
    logic [4:0] out_y;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    logic       sof_err;
    logic       frame_done;

    bayer_mosaic #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_red     (in_red),
        .in_green   (in_green),
        .in_blue    (in_blue),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .sof_err    (sof_err),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [5:0] x;
        logic [4:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t expQ[$];

    int  checks = 0;
    int  errors = 0;
    bit  inReset = 1'b1;
    int  readyMode = 0;
    int  cyc = 0;
    int  fireCount = 0;
    int  firstFire = 0;
    int  lastFire = 0;
    int  sofErrSeen = 0;
    int  frameDoneSeen = 0;

    // Frame model: a frame is just a running pixel index inside a frame.
    bit  inFrame = 1'b0;
    int  pixIdx = 0;
    int  expErr = 0;
    int  expFrames = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behaviour expected from one accepted pixel.
    task automatic modelAccept(input bit sof, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        int   px;
        int   py;
        if (sof) begin
            if (inFrame && pixIdx != 0) expErr++;
            inFrame = 1'b1;
            pixIdx  = 0;
        end
        if (inFrame) begin
            px = pixIdx % W;
            py = pixIdx / W;
            if (px % 2 == 0 && py % 2 == 0)      e.data = r;
            else if (px % 2 == 1 && py % 2 == 1) e.data = b;
            else                                  e.data = g;
            e.x   = 6'(px);
            e.y   = 5'(py);
            e.sof = (pixIdx == 0);
            e.eol = (px == W - 1);
            e.eof = (pixIdx == W * H - 1);
            expQ.push_back(e);
            pixIdx++;
            if (pixIdx == W * H) begin
                inFrame = 1'b0;
                pixIdx  = 0;
                expFrames++;
            end
        end
    endtask

    // Downstream readiness: always, 1-0-0-1 pattern, random, or held low.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (phase == 0 || phase == 3);
                    phase = (phase + 1) % 4;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        bit          prevStall = 1'b0;
        bit          prevFireEof = 1'b0;
        logic [21:0] held = '0;
        logic [21:0] cur;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {out_data, out_x, out_y, out_sof, out_eol, out_eof};
            if (inReset) begin
                prevStall   = 1'b0;
                prevFireEof = 1'b0;
            end else begin
                checkOutput("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
                if (prevStall) checkOutput("stall_hold", 32'(cur), 32'(held));
                checkOutput("frame_done", 32'(frame_done), 32'(prevFireEof));
                if (sof_err) sofErrSeen++;
                if (frame_done) frameDoneSeen++;
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_sample", 32'(cur), 32'hFFFF_FFFF);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("sample", 32'(cur),
                                    32'({e.data, e.x, e.y, e.sof, e.eol, e.eof}));
                    end
                    fireCount++;
                    if (fireCount == 1) firstFire = cyc;
                    lastFire = cyc;
                end
                prevStall   = out_valid && !out_ready;
                prevFireEof = out_valid && out_ready && out_eof;
                held        = cur;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit sof, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_red   = r;
        in_green = g;
        in_blue  = b;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clk);
            if (in_ready) begin
                modelAccept(sof, r, g, b);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Pixels at consecutive raster indices carrying R=x, G=0x80, B=y.
    task automatic sendPattern(input bit firstSof, input int startIdx, input int count);
        for (int i = 0; i < count; i++) begin
            int idx = startIdx + i;
            applyStimulus(firstSof && i == 0, 8'(idx % W), 8'h80, 8'(idx / W));
        end
    endtask

    task automatic sendRandom(input bit firstSof, input int count, input bit gaps, input bit randSof);
        for (int i = 0; i < count; i++) begin
            bit s = (firstSof && i == 0) || (randSof && $urandom_range(0, 99) == 0);
            applyStimulus(s, 8'($urandom), 8'($urandom), 8'($urandom));
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((expQ.size() != 0 || out_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        idle(3);
    endtask

    task automatic doReset();
        inReset  = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        inFrame = 1'b0;
        pixIdx  = 0;
        @(negedge clk);
        checkOutput("reset_outputs",
                    32'({out_valid, out_data, out_x, out_y, out_sof, out_eol, out_eof, sof_err, frame_done}),
                    32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        inReset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int errBefore;
        int doneBefore;

        // Reset, then pixels without in_sof in IDLE are dropped.
        doReset();
        fireCount = 0;
        errBefore = sofErrSeen;
        sendRandom(1'b0, 5, 1'b0, 1'b0);
        idle(3);
        checkOutput("idle_drop_outputs", 32'(fireCount), 32'd0);
        checkOutput("idle_drop_sof_err", 32'(sofErrSeen - errBefore), 32'd0);

        // Full frame at full throughput.
        fireCount  = 0;
        doneBefore = frameDoneSeen;
        sendPattern(1'b1, 0, W * H);
        drain();
        checkOutput("frame_count", 32'(fireCount), 32'(W * H));
        checkOutput("frame_cycles", 32'(lastFire - firstFire), 32'(W * H - 1));
        checkOutput("frame_done_once", 32'(frameDoneSeen - doneBefore), 32'd1);

        // Backpressure with a 1,0,0,1 ready pattern.
        readyMode = 1;
        fireCount = 0;
        sendRandom(1'b1, W * H, 1'b0, 1'b0);
        drain();
        checkOutput("bp_count", 32'(fireCount), 32'(W * H));
        readyMode = 0;
        idle(2);

        // in_sof arriving at (17,3) restarts the frame.
        errBefore = sofErrSeen;
        sendPattern(1'b1, 0, 3 * W + 17);
        applyStimulus(1'b1, 8'd17, 8'h80, 8'd3);
        sendPattern(1'b0, 1, W * H - 1);
        drain();
        checkOutput("midsof_err_pulses", 32'(sofErrSeen - errBefore), 32'd1);

        // Back-to-back frames with no bubble.
        fireCount  = 0;
        doneBefore = frameDoneSeen;
        sendPattern(1'b1, 0, W * H);
        sendPattern(1'b1, 0, W * H);
        drain();
        checkOutput("b2b_cycles", 32'(lastFire - firstFire), 32'(2 * W * H - 1));
        checkOutput("b2b_frame_done", 32'(frameDoneSeen - doneBefore), 32'd2);

        // Reset while the (10,5) sample is stalled, then a fresh frame.
        sendPattern(1'b1, 0, 5 * W + 11);
        readyMode = 3;
        out_ready = 1'b0;
        idle(4);
        checkOutput("stalled_valid", 32'(out_valid), 32'd1);
        doReset();
        readyMode = 0;
        sendPattern(1'b1, 0, W * H);
        drain();

        // Random traffic with random readiness, gaps and stray in_sof.
        readyMode = 2;
        sendRandom(1'b1, 900, 1'b1, 1'b1);
        drain();
        readyMode = 0;
        idle(4);

        checkOutput("sof_err_total", 32'(sofErrSeen), 32'(expErr));
        checkOutput("frame_done_total", 32'(frameDoneSeen), 32'(expFrames));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
